instruction_fetch_memory: RTL and testbench

Parametrised, clocked instruction memory for the CPU fetch stage. It holds a byte-addressed array and returns a little-endian, zero-extended instruction word for a requested PC. A ready/valid handshake carries an optional programmable wait-state count. A byte-wide load port preloads programs, and misaligned or out-of-range fetches are flagged instead of silently aliasing.

---
 rtl/instruction_fetch_memory.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch_memory.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_memory.sv
// instruction_fetch_memory
//   Byte-addressed instruction store for the fetch stage. A fetch is accepted
//   on fetchReq && fetchReady && !flush, the PC is latched, and after
//   WAIT_STATES extra cycles a one-cycle instrValid pulse presents the
//   little-endian, zero-extended instruction word (or a fault for misaligned /
//   out-of-range PCs). A byte-wide load port writes the array in every state.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset (does not clear memory)
//   fetchReq     fetch request
//   currentPc    byte address of the requested instruction
//   fetchReady   fetch can be accepted this cycle (decoded from state only)
//   instrValid   one-cycle pulse qualifying instruction / fault
//   instruction  fetched word, held between responses
//   fault        misaligned or out-of-range PC, held between responses
//   flush        abandon any pending fetch, block acceptance this cycle
//   loadEn       write loadByte to loadAddr
//   loadAddr     byte address of the write (out-of-range writes dropped)
//   loadByte     write data
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | nothing pending, ready for a fetch
// S_WAIT | fetch accepted, counting down wait states, not ready
// S_RESP | response presented this cycle, ready for the next fetch
module instruction_fetch_memory #(
  parameter int         ADDR_WIDTH  = 64,
  parameter int         DATA_WIDTH  = 64,
  parameter int         INSTR_BYTES = 4,
  parameter int         DEPTH_BYTES = 256,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] INIT_BYTE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] currentPc,
  output logic                  fetchReady,
  output logic                  instrValid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  fault,
  input  logic                  flush,
  input  logic                  loadEn,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [7:0]            loadByte
);

  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ADDR_WIDTH'(DEPTH_BYTES - INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Where an accepted fetch goes first: straight to the response when there
  // are no wait states.
  localparam state_t FIRST_STATE = (WAIT_STATES > 0) ? S_WAIT : S_RESP;

  logic [7:0] mem [DEPTH_BYTES] = '{default: INIT_BYTE};

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   sample_pc;
  logic [IDX_W-1:0]        rd_base;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rsp_fault;

  assign accept = fetchReq && fetchReady && !flush;

  // With no wait states the response edge is the acceptance edge, so the
  // PC being latched on that edge has to be taken straight from the port.
  assign sample_pc = (WAIT_STATES == 0) ? currentPc : pc_q;
  assign rd_base   = sample_pc[IDX_W-1:0];

  // Full-width compare: a huge PC must never alias into the array.
  assign rsp_fault = ((sample_pc & ALIGN_MASK) != '0) || (sample_pc > LAST_PC);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      rd_word[8*k +: 8] = mem[rd_base + IDX_W'(k)];
    end
  end

  // Load port is independent of reset and FSM state.
  always_ff @(posedge clk) begin
    if (loadEn && (loadAddr < DEPTH_A)) begin
      mem[loadAddr[IDX_W-1:0]] <= loadByte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_next = FIRST_STATE;
        S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
        S_RESP:  state_next = accept ? FIRST_STATE : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fetchReady = (state != S_WAIT);
    instrValid = (state == S_RESP);
  end

  // Wait counter, latched PC and response registers. The array read uses the
  // pre-edge memory contents, so a same-edge load returns the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      pc_q        <= '0;
      instruction <= '0;
      fault       <= 1'b0;
    end else begin
      if (flush) begin
        cnt <= 4'd0;
      end else if (accept) begin
        cnt  <= CNT_LOAD;
        pc_q <= currentPc;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (state_next == S_RESP) begin
        instruction <= rsp_fault ? '0 : rd_word;
        fault       <= rsp_fault;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Bench for instruction_fetch_memory: one instance with no wait states and one
// with two, driven by the same directed stimulus. A cycle-indexed model
// (pending fetch + due cycle + byte array) predicts both instances every cycle,
// and literal expectations pin the key scenarios.
module tb_instruction_fetch_memory;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetchReq, flush, loadEn;
  logic [63:0] currentPc, loadAddr;
  logic [7:0]  loadByte;

  logic        rdy [2];
  logic        vld [2];
  logic        flt [2];
  logic [63:0] ins [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  instruction_fetch_memory #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .INSTR_BYTES(4), .DEPTH_BYTES(256),
    .WAIT_STATES(0), .INIT_BYTE(8'h00)
  ) dut0 (
    .clk(clk), .rst(rst), .fetchReq(fetchReq), .currentPc(currentPc),
    .fetchReady(rdy[0]), .instrValid(vld[0]), .instruction(ins[0]), .fault(flt[0]),
    .flush(flush), .loadEn(loadEn), .loadAddr(loadAddr), .loadByte(loadByte)
  );

  instruction_fetch_memory #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .INSTR_BYTES(4), .DEPTH_BYTES(256),
    .WAIT_STATES(2), .INIT_BYTE(8'h00)
  ) dut2 (
    .clk(clk), .rst(rst), .fetchReq(fetchReq), .currentPc(currentPc),
    .fetchReady(rdy[1]), .instrValid(vld[1]), .instruction(ins[1]), .fault(flt[1]),
    .flush(flush), .loadEn(loadEn), .loadAddr(loadAddr), .loadByte(loadByte)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned mem_m [256];
  int           cyc_n = 0;
  bit           m_pend  [2];
  logic [63:0]  m_pc    [2];
  int           m_due   [2];
  bit           m_ready [2];
  bit           m_valid [2];
  logic [63:0]  m_instr [2];
  bit           m_fault [2];

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  always @(posedge clk) begin
    cyc_n = cyc_n + 1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (rst) begin
        m_pend[i]  = 1'b0;
        m_ready[i] = 1'b1;
        m_instr[i] = '0;
        m_fault[i] = 1'b0;
      end else begin
        if (flush) m_pend[i] = 1'b0;
        else if (fetchReq && m_ready[i]) begin
          m_pend[i] = 1'b1;
          m_pc[i]   = currentPc;
          m_due[i]  = cyc_n + ws_of(i);
        end
        if (m_pend[i] && (m_due[i] == cyc_n)) begin
          m_pend[i]  = 1'b0;
          m_valid[i] = 1'b1;
          m_fault[i] = (m_pc[i] % 64'd4 != 64'd0) || (m_pc[i] > 64'd252);
          m_instr[i] = '0;
          if (!m_fault[i])
            for (int k = 0; k < 4; k++)
              m_instr[i][8*k +: 8] = mem_m[int'(m_pc[i]) + k];
        end
        m_ready[i] = !m_pend[i];
      end
    end
    // Loads land after the sample so a same-edge read sees the old byte.
    if (loadEn && (loadAddr < 64'd256)) mem_m[int'(loadAddr)] = loadByte;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model dut%0d fetchReady", i), 64'(rdy[i]), 64'(m_ready[i]));
        chk($sformatf("model dut%0d instrValid", i), 64'(vld[i]), 64'(m_valid[i]));
        chk($sformatf("model dut%0d instruction", i), ins[i], m_instr[i]);
        chk($sformatf("model dut%0d fault", i), 64'(flt[i]), 64'(m_fault[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [7:0] b);
    loadEn = 1'b1; loadAddr = a; loadByte = b;
    cyc();
    loadEn = 1'b0;
  endtask

  // One fetch; dut0 answers after one edge, dut2 after three.
  task automatic fetch_lit(input logic [63:0] pc, input logic [63:0] exp_i,
                           input logic exp_f, input string nm);
    fetchReq = 1'b1; currentPc = pc;
    cyc();
    fetchReq = 1'b0; currentPc = 64'hFFFF_FFFF_FFFF_FFF1;
    chk({nm, " dut0 valid"}, 64'(vld[0]), 64'd1);
    chk({nm, " dut0 instr"}, ins[0], exp_i);
    chk({nm, " dut0 fault"}, 64'(flt[0]), 64'(exp_f));
    chk({nm, " dut2 busy"}, 64'(rdy[1]), 64'd0);
    cyc();
    chk({nm, " dut2 early valid"}, 64'(vld[1]), 64'd0);
    cyc();
    chk({nm, " dut2 valid"}, 64'(vld[1]), 64'd1);
    chk({nm, " dut2 instr"}, ins[1], exp_i);
    chk({nm, " dut2 fault"}, 64'(flt[1]), 64'(exp_f));
  endtask

  logic [63:0] words [4] = '{64'h0302_0123, 64'h1716_1514, 64'h1B1A_1918, 64'h1F1E_1D1C};

  initial begin
    rst = 1'b1; fetchReq = 1'b0; flush = 1'b0; loadEn = 1'b0;
    currentPc = '0; loadAddr = '0; loadByte = '0;
    cyc();
    // Program bytes 0..3 while still in reset.
    load(64'd0, 8'h23); load(64'd1, 8'h01); load(64'd2, 8'h02); load(64'd3, 8'h03);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset dut%0d fetchReady", i), 64'(rdy[i]), 64'd1);
      chk($sformatf("reset dut%0d instrValid", i), 64'(vld[i]), 64'd0);
      chk($sformatf("reset dut%0d instruction", i), ins[i], 64'd0);
      chk($sformatf("reset dut%0d fault", i), 64'(flt[i]), 64'd0);
    end
    rst = 1'b0;
    chk_en = 1'b1;

    for (int a = 4; a < 16; a++) load(64'(a), 8'(8'h10 + a));
    load(64'd252, 8'hDE); load(64'd253, 8'hAD); load(64'd254, 8'hBE); load(64'd255, 8'hEF);
    load(64'd256, 8'h55);
    load(64'h1_0000_0000, 8'h77);

    fetch_lit(64'd0,   64'h0000_0000_0302_0123, 1'b0, "pc0");
    fetch_lit(64'd2,   64'd0, 1'b1, "pc2 misaligned");
    fetch_lit(64'd256, 64'd0, 1'b1, "pc256 range");
    fetch_lit(64'h1_0000_0000, 64'd0, 1'b1, "pc 2^32 no wrap");
    fetch_lit(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, "pc top no wrap");
    fetch_lit(64'd252, 64'h0000_0000_EFBE_ADDE, 1'b0, "pc252 last");
    fetch_lit(64'd0,   64'h0000_0000_0302_0123, 1'b0, "pc0 after dropped loads");

    // Held request on the wait-state instance: accepts every third edge.
    for (int j = 0; j <= 10; j++) begin
      fetchReq  = (j <= 6);
      currentPc = 64'((j / 3) * 4);
      cyc();
      chk($sformatf("ws2 stream ready j=%0d", j), 64'(rdy[1]),
          64'(((j % 3) == 2) || (j >= 8)));
      chk($sformatf("ws2 stream valid j=%0d", j), 64'(vld[1]),
          64'(((j % 3) == 2) && (j <= 8)));
      if (((j % 3) == 2) && (j <= 8))
        chk($sformatf("ws2 stream instr j=%0d", j), ins[1], words[j / 3]);
    end
    fetchReq = 1'b0;

    // Back-to-back on the zero-wait instance.
    for (int j = 0; j < 4; j++) begin
      fetchReq = 1'b1; currentPc = 64'(4 * j);
      cyc();
      chk($sformatf("b2b valid %0d", j), 64'(vld[0]), 64'd1);
      chk($sformatf("b2b instr %0d", j), ins[0], words[j]);
    end
    fetchReq = 1'b0;
    cyc();
    chk("b2b valid drops", 64'(vld[0]), 64'd0);
    cyc(); cyc(); cyc();

    // Flush during WAIT, with a request held in the flush cycle.
    fetchReq = 1'b1; currentPc = 64'd4;
    cyc();
    chk("flush-cycle resp valid", 64'(vld[0]), 64'd1);
    chk("flush-cycle resp instr", ins[0], 64'h1716_1514);
    flush = 1'b1; currentPc = 64'd8;
    cyc();
    flush = 1'b0; fetchReq = 1'b0;
    chk("flush ready", 64'(rdy[1]), 64'd1);
    chk("flush blocks accept", 64'(vld[0]), 64'd0);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk($sformatf("flush no valid %0d", j), 64'(vld[1]), 64'd0);
    end

    // Reset during WAIT.
    fetchReq = 1'b1; currentPc = 64'd8;
    cyc();
    fetchReq = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst dut%0d fetchReady", i), 64'(rdy[i]), 64'd1);
      chk($sformatf("midrst dut%0d instrValid", i), 64'(vld[i]), 64'd0);
      chk($sformatf("midrst dut%0d instruction", i), ins[i], 64'd0);
      chk($sformatf("midrst dut%0d fault", i), 64'(flt[i]), 64'd0);
    end
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk($sformatf("rst no valid %0d", j), 64'(vld[1]), 64'd0);
    end
    fetch_lit(64'd8, 64'h1B1A_1918, 1'b0, "mem kept over rst");

    // Load colliding with the sampling edge.
    fetchReq = 1'b1; currentPc = 64'd0;
    loadEn = 1'b1; loadAddr = 64'd0; loadByte = 8'hAA;
    cyc();
    fetchReq = 1'b0; loadEn = 1'b0;
    chk("collide ws0 old byte", ins[0], 64'h0302_0123);
    cyc(); cyc();
    chk("collide ws2 valid", 64'(vld[1]), 64'd1);
    chk("collide ws2 later sample", ins[1], 64'h0302_01AA);
    fetch_lit(64'd0, 64'h0302_01AA, 1'b0, "after collide pc0");

    fetchReq = 1'b1; currentPc = 64'd4;
    cyc();
    fetchReq = 1'b0;
    chk("pc4 ws0", ins[0], 64'h1716_1514);
    cyc();
    loadEn = 1'b1; loadAddr = 64'd4; loadByte = 8'hBB;
    cyc();
    loadEn = 1'b0;
    chk("collide ws2 edge valid", 64'(vld[1]), 64'd1);
    chk("collide ws2 edge old byte", ins[1], 64'h1716_1514);
    fetch_lit(64'd4, 64'h1716_15BB, 1'b0, "after collide pc4");

    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
